// File: rtl/redmule_ldst_arbiter.sv
// N-channel load/store arbiter for the RedMulE streamer: merges request channels onto one
// TCDM port and routes in-order read responses back to the issuing channel.
module redmule_ldst_arbiter #(
  parameter int unsigned NB_CHAN   = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 256,
  parameter int unsigned MAX_OUTST = 8,
  localparam int unsigned BW       = DW / 8,
  localparam int unsigned CW       = $clog2(MAX_OUTST + 1),
  localparam int unsigned CHW      = $clog2(NB_CHAN)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  priority_force_i,
  input  logic [CHW-1:0]        priority_i,
  input  logic [NB_CHAN-1:0]    in_req_valid_i,
  output logic [NB_CHAN-1:0]    in_req_ready_o,
  input  logic [NB_CHAN*AW-1:0] in_req_add_i,
  input  logic [NB_CHAN-1:0]    in_req_wen_i,
  input  logic [NB_CHAN*DW-1:0] in_req_data_i,
  input  logic [NB_CHAN*BW-1:0] in_req_be_i,
  output logic [NB_CHAN-1:0]    in_resp_valid_o,
  input  logic [NB_CHAN-1:0]    in_resp_ready_i,
  output logic [DW-1:0]         in_resp_data_o,
  output logic                  out_req_valid_o,
  input  logic                  out_req_ready_i,
  output logic [AW-1:0]         out_req_add_o,
  output logic                  out_req_wen_o,
  output logic [DW-1:0]         out_req_data_o,
  output logic [BW-1:0]         out_req_be_o,
  input  logic                  out_resp_valid_i,
  output logic                  out_resp_ready_o,
  input  logic [DW-1:0]         out_resp_data_i,
  output logic [NB_CHAN*CW-1:0] outst_cnt_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned DEPTH = NB_CHAN * MAX_OUTST;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned FCW   = $clog2(DEPTH + 1);

  logic [CHW-1:0] rr_q, rr_d;
  logic           lock_q, lock_d;
  logic [CHW-1:0] lock_idx_q, lock_idx_d;
  logic [CW-1:0]  cnt_q [NB_CHAN];
  logic [CW-1:0]  cnt_d [NB_CHAN];
  logic [CHW-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           err_q, err_d;

  logic [NB_CHAN-1:0] eligible;
  logic               gnt_valid;
  logic [CHW-1:0]     gnt_idx;
  logic               req_hs, push, pop, fifo_empty;
  logic [CHW-1:0]     head;

  function automatic logic [CHW-1:0] wrap_add(input logic [CHW-1:0] base, input int unsigned off);
    int unsigned s;
    s = int'(base) + off;
    if (s >= NB_CHAN) s = s - NB_CHAN;
    return CHW'(s);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A channel issuing a read at its credit limit must wait; writes always proceed.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NB_CHAN; i++) begin
      eligible[i] = in_req_valid_i[i] & ~(in_req_wen_i[i] & (cnt_q[i] == CW'(MAX_OUTST)));
    end
  end

  // Lock beats forced priority beats round-robin; lowest offset from rr_q wins the scan.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (lock_q) begin
      gnt_valid = 1'b1;
      gnt_idx   = lock_idx_q;
    end else if (priority_force_i && eligible[priority_i]) begin
      gnt_valid = 1'b1;
      gnt_idx   = priority_i;
    end else begin
      for (int unsigned k = 0; k < NB_CHAN; k++) begin
        if (eligible[wrap_add(rr_q, NB_CHAN - 1 - k)]) begin
          gnt_valid = 1'b1;
          gnt_idx   = wrap_add(rr_q, NB_CHAN - 1 - k);
        end
      end
    end
  end

  assign out_req_valid_o = gnt_valid;
  assign out_req_add_o   = in_req_add_i[gnt_idx*AW +: AW];
  assign out_req_wen_o   = in_req_wen_i[gnt_idx];
  assign out_req_data_o  = in_req_data_i[gnt_idx*DW +: DW];
  assign out_req_be_o    = in_req_be_i[gnt_idx*BW +: BW];

  assign req_hs     = gnt_valid & out_req_ready_i;
  assign push       = req_hs & in_req_wen_i[gnt_idx];
  assign fifo_empty = (fcnt_q == '0);
  assign head       = fifo_mem[rd_ptr_q];
  assign pop        = out_resp_valid_i & ~fifo_empty & in_resp_ready_i[head];

  // Untracked responses are accepted and dropped so the memory side never stalls.
  assign out_resp_ready_o = fifo_empty ? out_resp_valid_i : in_resp_ready_i[head];
  assign in_resp_data_o   = out_resp_data_i;

  always_comb begin
    in_req_ready_o  = '0;
    in_resp_valid_o = '0;
    if (gnt_valid)   in_req_ready_o[gnt_idx] = out_req_ready_i;
    if (!fifo_empty) in_resp_valid_o[head]   = out_resp_valid_i;
  end

  always_comb begin
    outst_cnt_o = '0;
    for (int unsigned i = 0; i < NB_CHAN; i++) outst_cnt_o[i*CW +: CW] = cnt_q[i];
  end

  assign busy_o = ~fifo_empty;
  assign err_o  = err_q;

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fcnt_d     = fcnt_q + FCW'(push) - FCW'(pop);
    err_d      = err_q | (out_resp_valid_i & fifo_empty);
    if (req_hs) begin
      rr_d   = wrap_add(gnt_idx, 1);
      lock_d = 1'b0;
    end else if (gnt_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
    for (int unsigned i = 0; i < NB_CHAN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (push && gnt_idx == CHW'(i) && !(pop && head == CHW'(i)))
        cnt_d[i] = cnt_q[i] + 1'b1;
      else if (pop && head == CHW'(i) && !(push && gnt_idx == CHW'(i)))
        cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < NB_CHAN; i++) cnt_q[i] <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      err_q      <= err_d;
      for (int unsigned i = 0; i < NB_CHAN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Route storage needs no reset: occupancy is tracked by the pointers and fcnt_q.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= gnt_idx;
  end

endmodule

// File: tb/tb_redmule_ldst_arbiter.sv
// Scoreboard bench for redmule_ldst_arbiter: stimulus queues expected grants and responses,
// negedge monitors pop and compare on every handshake.
module tb_redmule_ldst_arbiter;
  localparam int unsigned NB_CHAN = 4, AW = 32, DW = 256, MAX_OUTST = 8;
  localparam int unsigned BW = DW / 8, CW = 4, CHW = 2;

  logic                  clk = 1'b0;
  logic                  rst_i, clear_i, priority_force_i;
  logic [CHW-1:0]        priority_i;
  logic [NB_CHAN-1:0]    in_req_valid_i, in_req_ready_o, in_req_wen_i;
  logic [NB_CHAN*AW-1:0] in_req_add_i;
  logic [NB_CHAN*DW-1:0] in_req_data_i;
  logic [NB_CHAN*BW-1:0] in_req_be_i;
  logic [NB_CHAN-1:0]    in_resp_valid_o, in_resp_ready_i;
  logic [DW-1:0]         in_resp_data_o;
  logic                  out_req_valid_o, out_req_ready_i, out_req_wen_o;
  logic [AW-1:0]         out_req_add_o;
  logic [DW-1:0]         out_req_data_o;
  logic [BW-1:0]         out_req_be_o;
  logic                  out_resp_valid_i, out_resp_ready_o;
  logic [DW-1:0]         out_resp_data_i;
  logic [NB_CHAN*CW-1:0] outst_cnt_o;
  logic                  busy_o, err_o;

  redmule_ldst_arbiter #(.NB_CHAN(NB_CHAN), .AW(AW), .DW(DW), .MAX_OUTST(MAX_OUTST)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .priority_force_i(priority_force_i), .priority_i(priority_i),
    .in_req_valid_i(in_req_valid_i), .in_req_ready_o(in_req_ready_o),
    .in_req_add_i(in_req_add_i), .in_req_wen_i(in_req_wen_i),
    .in_req_data_i(in_req_data_i), .in_req_be_i(in_req_be_i),
    .in_resp_valid_o(in_resp_valid_o), .in_resp_ready_i(in_resp_ready_i),
    .in_resp_data_o(in_resp_data_o),
    .out_req_valid_o(out_req_valid_o), .out_req_ready_i(out_req_ready_i),
    .out_req_add_o(out_req_add_o), .out_req_wen_o(out_req_wen_o),
    .out_req_data_o(out_req_data_o), .out_req_be_o(out_req_be_o),
    .out_resp_valid_i(out_resp_valid_i), .out_resp_ready_o(out_resp_ready_o),
    .out_resp_data_i(out_resp_data_i),
    .outst_cnt_o(outst_cnt_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int            q_gnt_ch[$];
  logic [AW-1:0] q_gnt_add[$];
  int            q_rsp_ch[$];
  logic [DW-1:0] q_rsp_data[$];

  function automatic logic [AW-1:0] mkaddr(input int ch, input int n);
    return 32'h1000_0000 | (32'(ch) << 16) | 32'(n);
  endfunction

  function automatic logic [DW-1:0] mkdata(input int k);
    return {8{32'hD000_0000 + 32'(k)}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic wen, input logic [AW-1:0] a);
    in_req_valid_i[ch]          = v;
    in_req_wen_i[ch]            = wen;
    in_req_add_i[ch*AW +: AW]   = a;
    in_req_data_i[ch*DW +: DW]  = {8{a}};
    in_req_be_i[ch*BW +: BW]    = '1;
  endtask

  task automatic exp_gnt(input int ch, input logic [AW-1:0] a);
    q_gnt_ch.push_back(ch);
    q_gnt_add.push_back(a);
  endtask

  // Single-channel read issued in one cycle.
  task automatic rd(input int ch, input int n);
    set_ch(ch, 1'b1, 1'b1, mkaddr(ch, n));
    exp_gnt(ch, mkaddr(ch, n));
    step();
    set_ch(ch, 1'b0, 1'b1, '0);
  endtask

  task automatic resp(input int ch, input int k);
    out_resp_valid_i = 1'b1;
    out_resp_data_i  = mkdata(k);
    q_rsp_ch.push_back(ch);
    q_rsp_data.push_back(mkdata(k));
    step();
    out_resp_valid_i = 1'b0;
  endtask

  // Request-side monitor.
  always @(negedge clk) begin
    int ch;
    logic [AW-1:0] a;
    if (out_req_valid_o && out_req_ready_i) begin
      n_vec++;
      if (q_gnt_ch.size() == 0) begin
        n_err++;
        $display("FAIL gnt_unexpected: got ready %b addr %h expected no grant", in_req_ready_o, out_req_add_o);
      end else begin
        ch = q_gnt_ch.pop_front();
        a  = q_gnt_add.pop_front();
        if (in_req_ready_o !== 4'(1 << ch) || out_req_add_o !== a) begin
          n_err++;
          $display("FAIL gnt: got ready %b addr %h expected ready %b addr %h",
                   in_req_ready_o, out_req_add_o, 4'(1 << ch), a);
        end
      end
    end
  end

  // Response-side monitor; dropped responses show no channel valid and are skipped.
  always @(negedge clk) begin
    int ch;
    logic [DW-1:0] d;
    if (out_resp_valid_i && out_resp_ready_o && (|in_resp_valid_o)) begin
      n_vec++;
      if (q_rsp_ch.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got valid %b expected none", in_resp_valid_o);
      end else begin
        ch = q_rsp_ch.pop_front();
        d  = q_rsp_data.pop_front();
        if (in_resp_valid_o !== 4'(1 << ch) || in_resp_data_o !== d) begin
          n_err++;
          $display("FAIL rsp: got valid %b data %h expected valid %b data %h",
                   in_resp_valid_o, in_resp_data_o[31:0], 4'(1 << ch), d[31:0]);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; priority_force_i = 1'b0; priority_i = '0;
    in_req_valid_i = '0; in_req_wen_i = '0; in_req_add_i = '0; in_req_data_i = '0; in_req_be_i = '0;
    in_resp_ready_i = '1; out_req_ready_i = 1'b1; out_resp_valid_i = 1'b0; out_resp_data_i = '0;
    step(); step();
    chk("rst_cnt", 64'(outst_cnt_o), 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    chk("rst_req_valid", 64'(out_req_valid_o), 64'h0);
    rst_i = 1'b0;

    // Round-robin across four reading channels.
    for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 1'b1, mkaddr(c, 0));
    exp_gnt(0, mkaddr(0, 0)); exp_gnt(1, mkaddr(1, 0)); exp_gnt(2, mkaddr(2, 0));
    exp_gnt(3, mkaddr(3, 0)); exp_gnt(0, mkaddr(0, 0));
    repeat (5) step();
    in_req_valid_i = '0;
    chk("rr_cnt", 64'(outst_cnt_o), 64'h1112);
    chk("rr_busy", 64'(busy_o), 64'h1);
    resp(0, 1); resp(1, 2); resp(2, 3); resp(3, 4); resp(0, 5);
    chk("rr_cnt_drain", 64'(outst_cnt_o), 64'h0);

    // Credit limit on ch1.
    for (int n = 0; n < 8; n++) rd(1, n);
    chk("cr_cnt8", 64'(outst_cnt_o), 64'h0080);
    set_ch(1, 1'b1, 1'b1, mkaddr(1, 8));
    #2;
    chk("cr_blocked_valid", 64'(out_req_valid_o), 64'h0);
    chk("cr_blocked_ready", 64'(in_req_ready_o), 64'h0);
    set_ch(2, 1'b1, 1'b1, mkaddr(2, 8));
    exp_gnt(2, mkaddr(2, 8));
    #1;
    chk("cr_ch2_ready", 64'(in_req_ready_o), 64'b0100);
    step();
    set_ch(2, 1'b0, 1'b1, '0);
    set_ch(1, 1'b1, 1'b0, mkaddr(1, 9));
    exp_gnt(1, mkaddr(1, 9));
    step();
    set_ch(1, 1'b1, 1'b1, mkaddr(1, 10));
    #2;
    chk("cr_still_blocked", 64'(out_req_valid_o), 64'h0);
    resp(1, 10);
    exp_gnt(1, mkaddr(1, 10));
    chk("cr_freed_ready", 64'(in_req_ready_o), 64'b0010);
    step();
    set_ch(1, 1'b0, 1'b1, '0);
    chk("cr_cnt_after", 64'(outst_cnt_o), 64'h0180);
    for (int k = 0; k < 7; k++) resp(1, 20 + k);
    resp(2, 30); resp(1, 31);
    chk("cr_cnt_drain", 64'(outst_cnt_o), 64'h0);
    chk("cr_busy_drain", 64'(busy_o), 64'h0);

    // Routing with backpressure on ch0.
    rd(2, 40); rd(0, 41); rd(2, 42);
    resp(2, 50);
    in_resp_ready_i = 4'b1110;
    out_resp_valid_i = 1'b1;
    out_resp_data_i = mkdata(51);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("bp_ready", 64'(out_resp_ready_o), 64'h0);
      chk("bp_valid", 64'(in_resp_valid_o), 64'b0001);
      step();
    end
    in_resp_ready_i = '1;
    q_rsp_ch.push_back(0); q_rsp_data.push_back(mkdata(51));
    step();
    out_resp_valid_i = 1'b0;
    resp(2, 52);
    chk("route_cnt", 64'(outst_cnt_o), 64'h0);

    // Grant lock on ch3 survives forced priority to ch1.
    out_req_ready_i = 1'b0;
    set_ch(3, 1'b1, 1'b1, mkaddr(3, 60));
    #2;
    chk("lk_valid", 64'(out_req_valid_o), 64'h1);
    step();
    set_ch(1, 1'b1, 1'b1, mkaddr(1, 61));
    priority_force_i = 1'b1; priority_i = 2'd1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("lk_add", 64'(out_req_add_o), 64'(mkaddr(3, 60)));
      step();
    end
    out_req_ready_i = 1'b1;
    exp_gnt(3, mkaddr(3, 60));
    #2;
    chk("lk_ready", 64'(in_req_ready_o), 64'b1000);
    step();
    set_ch(3, 1'b0, 1'b1, '0);
    exp_gnt(1, mkaddr(1, 61));
    step();
    set_ch(1, 1'b0, 1'b1, '0);
    priority_force_i = 1'b0;
    resp(3, 62); resp(1, 63);

    // Same-cycle push and pop on ch0 leaves the counter unchanged.
    rd(0, 70); rd(0, 71); rd(0, 72);
    chk("sim_cnt_pre", 64'(outst_cnt_o), 64'h0003);
    set_ch(0, 1'b1, 1'b1, mkaddr(0, 73));
    exp_gnt(0, mkaddr(0, 73));
    resp(0, 74);
    set_ch(0, 1'b0, 1'b1, '0);
    chk("sim_cnt_post", 64'(outst_cnt_o), 64'h0003);
    resp(0, 75); resp(0, 76); resp(0, 77);
    chk("sim_cnt_drain", 64'(outst_cnt_o), 64'h0);

    // Reset with reads in flight; the stale response is dropped and flagged.
    for (int n = 0; n < 5; n++) rd(0, 80 + n);
    chk("mr_cnt", 64'(outst_cnt_o), 64'h0005);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mr_cnt0", 64'(outst_cnt_o), 64'h0);
    chk("mr_busy0", 64'(busy_o), 64'h0);
    chk("mr_err0", 64'(err_o), 64'h0);
    out_resp_valid_i = 1'b1;
    out_resp_data_i = mkdata(90);
    #2;
    chk("drop_ready", 64'(out_resp_ready_o), 64'h1);
    chk("drop_valid", 64'(in_resp_valid_o), 64'h0);
    step();
    out_resp_valid_i = 1'b0;
    chk("drop_err", 64'(err_o), 64'h1);
    chk("drop_cnt", 64'(outst_cnt_o), 64'h0);
    step();
    chk("err_sticky", 64'(err_o), 64'h1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("clr_err", 64'(err_o), 64'h0);

    step();
    chk("gnt_queue_left", 64'(q_gnt_ch.size()), 64'h0);
    chk("rsp_queue_left", 64'(q_rsp_ch.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/redmule_ldst_arbiter.md
Name: redmule_ldst_arbiter

Overview:
- Parametrised N-channel load/store arbiter with outstanding-transaction tracking; next generation of the streamer's fixed 4-way ld/st mux plus per-channel ROB pair.
- Merges NB_CHAN request channels (X/W/Y/Z sources and sinks, or more) onto one TCDM initiator port.
- Tracks every read in flight and routes in-order read responses back to the issuing channel.
- Adds per-channel outstanding credit limits, a lockable round-robin grant and a forced-priority mode.

Parameters:
- NB_CHAN, 4, number of request channels (>=2).
- AW, 32, address width.
- DW, 256, data width; BW = DW/8 byte enables.
- MAX_OUTST, 8, maximum reads in flight per channel (power of 2, >=2).
- CW, $clog2(MAX_OUTST+1), credit counter width (derived).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- clear_i  in  1  synchronous soft clear, same effect as rst_i
- priority_force_i  in  1  when high, priority_i channel wins arbitration
- priority_i  in  $clog2(NB_CHAN)  forced-priority channel index
- in_req_valid_i  in  NB_CHAN  per-channel request valid
- in_req_ready_o  out  NB_CHAN  per-channel request ready
- in_req_add_i  in  NB_CHAN*AW  per-channel address
- in_req_wen_i  in  NB_CHAN  1 = read, 0 = write
- in_req_data_i  in  NB_CHAN*DW  write data
- in_req_be_i  in  NB_CHAN*BW  byte enables
- in_resp_valid_o  out  NB_CHAN  per-channel response valid (one-hot or zero)
- in_resp_ready_i  in  NB_CHAN  per-channel response ready
- in_resp_data_o  out  DW  response data, broadcast to all channels
- out_req_valid_o  out  1  TCDM request valid
- out_req_ready_i  in  1  TCDM request ready
- out_req_add_o, out_req_wen_o, out_req_data_o, out_req_be_o  out  AW, 1, DW, BW  selected request fields
- out_resp_valid_i  in  1  TCDM response valid (reads only, in issue order)
- out_resp_ready_o  out  1  TCDM response ready
- out_resp_data_i  in  DW  TCDM response data
- outst_cnt_o  out  NB_CHAN*CW  per-channel reads in flight
- busy_o  out  1  any read in flight
- err_o  out  1  sticky: response received with no tracked read

Behaviour:
Reset/clear (rst_i or clear_i sampled high):
- RR pointer = 0, grant lock cleared, all counters = 0, route FIFO emptied, err_o = 0.
- All outputs then follow: valid/ready outputs 0, busy_o = 0, outst_cnt_o = 0.
- Reset mid-operation discards all tracking. Responses to reads issued before reset fall under the empty-FIFO rule below.

Eligibility:
- Channel i is eligible if in_req_valid_i[i] is high and it is not read-blocked.
- Read-blocked: in_req_wen_i[i] = 1 and its counter = MAX_OUTST. Writes are never credit-blocked.

Grant:
- If priority_force_i is high and channel priority_i is eligible, it is granted.
- Otherwise grant the first eligible channel scanning upward from the RR pointer, wrapping NB_CHAN-1 -> 0.
- Request path is combinational (0-cycle): out_req_* = granted channel's fields; out_req_valid_o = any grant.
- in_req_ready_o[g] = out_req_ready_i for the granted channel only; all other bits 0.

Grant lock:
- If out_req_valid_o = 1 and out_req_ready_i = 0, the grant is registered and held on following cycles until handshake, regardless of priority changes.
- A locked channel keeps its grant even if it becomes read-blocked.

Handshake on granted channel g:
- RR pointer <= (g+1) mod NB_CHAN; lock released.
- If read: counter[g] increments and g is pushed into the route FIFO.
- Route FIFO depth is NB_CHAN*MAX_OUTST, so it cannot overflow.

Response path (combinational):
- Head h of the route FIFO selects the channel.
- in_resp_valid_o[h] = out_resp_valid_i; in_resp_data_o = out_resp_data_i; out_resp_ready_o = in_resp_ready_i[h].
- On response handshake: pop FIFO, counter[h] decrements.

Counter and FIFO edge cases:
- Same-cycle request push and response pop of the same channel: counter unchanged; FIFO push and pop both occur. A full FIFO may pop and push in the same cycle.
- Empty route FIFO with out_resp_valid_i = 1: out_resp_ready_o = 1, response dropped, no in_resp_valid_o, err_o set.
- err_o holds until rst_i/clear_i.

busy_o = route FIFO not empty.

Test Plan:
- Reset: all 4 channels valid (reads), ready=1 -> grants 0,1,2,3,0 on consecutive cycles; outst_cnt_o = {2,1,1,1} after 5 cycles.
- Credit limit: MAX_OUTST=8, ch1 issues 8 reads with no response -> 9th read gets in_req_ready_o[1]=0 while ch1 writes and ch2 reads still issue. One response to ch1 frees the credit next cycle.
- Response routing: reads issued ch2, ch0, ch2, then 3 responses D0, D1, D2 -> in_resp_valid_o = 0100, 0001, 0100 with matching data. Backpressure in_resp_ready_i[0]=0 for 3 cycles stalls out_resp_ready_o.
- Lock/priority: ch3 granted with out_req_ready_i=0 for 4 cycles, then priority_force_i=1, priority_i=1 -> ch3 stays granted until handshake; next grant is ch1.
- Simultaneous: ch0 read handshake and ch0 response in the same cycle at counter=3 -> counter stays 3. Reset asserted with 5 reads in flight, then a response arrives -> dropped, err_o=1, outst_cnt_o=0.
